// File: rtl/cpu_pkg.sv
// Shared core types and widths; WORD/ADDR_SIZE must agree with reg_file.
package cpu_pkg;
  localparam int WORD      = 8;
  localparam int ADDR_SIZE = 2;
  localparam int OP_W      = 4;

  typedef logic [WORD-1:0]      word_t;
  typedef logic [ADDR_SIZE-1:0] reg_addr_t;
  typedef logic [OP_W-1:0]      opcode_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decoder / reg_file / execute bundle around operand_fetch; slave is the stage's view.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic      in_valid;
  logic      in_ready;
  opcode_t   in_op;
  reg_addr_t in_ra;
  reg_addr_t in_rb;
  reg_addr_t in_rd;
  word_t     in_imm;

  reg_addr_t rf_rd_addr1;
  reg_addr_t rf_rd_addr2;
  word_t     rf_rd_data1;
  word_t     rf_rd_data2;
  reg_addr_t rf_wr_addr;
  word_t     rf_wr_data;
  logic      rf_wr_en;

  logic      wb_en;
  reg_addr_t wb_addr;
  word_t     wb_data;

  logic      out_valid;
  logic      out_ready;
  opcode_t   out_op;
  reg_addr_t out_rd;
  word_t     out_imm;
  word_t     out_a;
  word_t     out_b;

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_rd, in_imm,
    input  rf_rd_data1, rf_rd_data2,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_data, rf_wr_en,
    output out_valid, out_op, out_rd, out_imm, out_a, out_b
  );

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_rd, in_imm,
    output rf_rd_data1, rf_rd_data2,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_data, rf_wr_en,
    input  out_valid, out_op, out_rd, out_imm, out_a, out_b
  );
endinterface

// File: rtl/operand_fwd.sv
// One operand's forwarding mux plus holding register; the held value tracks the
// mux output every cycle the stage is occupied so stalls never lose write-backs.
module operand_fwd
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      accept,
  input  logic      b_valid,
  input  logic      b_fresh,
  input  reg_addr_t in_addr,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  word_t     wb_data,
  input  word_t     rf_data,
  output word_t     opnd
);
  reg_addr_t b_addr;
  logic      fwd_hit;
  word_t     fwd_data;
  word_t     held;

  // reg_file returns the pre-write value on a same-edge write, so capture it here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_addr   <= '0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (accept) begin
      b_addr   <= in_addr;
      fwd_hit  <= wb_en && (wb_addr == in_addr);
      fwd_data <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else if (b_valid) begin
      held <= opnd;
    end
  end

  always_comb begin
    opnd = held;
    if (wb_en && (wb_addr == b_addr)) begin
      opnd = wb_data;
    end else if (b_fresh && fwd_hit) begin
      opnd = fwd_data;
    end else if (b_fresh) begin
      opnd = rf_data;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: single-entry register absorbing reg_file read latency,
// forwarding write-back into both operands; throughput one instruction per cycle.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_if.slave    bus
);
  logic      b_valid;
  logic      b_fresh;
  opcode_t   b_op;
  reg_addr_t b_rd;
  word_t     b_imm;
  logic      accept;
  logic      consume;

  assign bus.in_ready = !b_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = b_valid && bus.out_ready;

  assign bus.rf_rd_addr1 = bus.in_ra;
  assign bus.rf_rd_addr2 = bus.in_rb;
  assign bus.rf_wr_addr  = bus.wb_addr;
  assign bus.rf_wr_data  = bus.wb_data;
  assign bus.rf_wr_en    = bus.wb_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_fresh <= 1'b0;
    end else begin
      b_fresh <= accept;
      if (accept) begin
        b_valid <= 1'b1;
      end else if (consume) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_op  <= '0;
      b_rd  <= '0;
      b_imm <= '0;
    end else if (accept) begin
      b_op  <= bus.in_op;
      b_rd  <= bus.in_rd;
      b_imm <= bus.in_imm;
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.out_op    = b_op;
  assign bus.out_rd    = b_rd;
  assign bus.out_imm   = b_imm;

  operand_fwd u_fwd_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .b_valid (b_valid),
    .b_fresh (b_fresh),
    .in_addr (bus.in_ra),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .rf_data (bus.rf_rd_data1),
    .opnd    (bus.out_a)
  );

  operand_fwd u_fwd_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .b_valid (b_valid),
    .b_fresh (b_fresh),
    .in_addr (bus.in_rb),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .rf_data (bus.rf_rd_data2),
    .opnd    (bus.out_b)
  );
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural one-cycle-read reg_file.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reg_file model: registered reads return the pre-write value on a same-edge write
  logic [7:0] rf [4];
  initial for (int i = 0; i < 4; i++) rf[i] = 8'h00;
  always @(posedge clk) begin
    bus.rf_rd_data1 <= rf[bus.rf_rd_addr1];
    bus.rf_rd_data2 <= rf[bus.rf_rd_addr2];
    if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_ra    = '0;
    bus.in_rb    = '0;
    bus.in_rd    = '0;
    bus.in_imm   = '0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic [7:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
  endtask

  task automatic writeback(input logic [1:0] addr, input logic [7:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_tests++; if (bus.out_op !== 4'h0) begin n_fail++; $display("FAIL reset_out_op got %h exp 0", bus.out_op); end
    n_tests++; if (bus.out_a !== 8'h00) begin n_fail++; $display("FAIL reset_out_a got %h exp 00", bus.out_a); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_preload_and_basic();
    writeback(2'd1, 8'h3C); step();
    writeback(2'd2, 8'hA5); step();
    bus.wb_en = 1'b0;
    issue(4'h5, 2'd1, 2'd2, 2'd3, 8'h42);
    step();
    bus.in_valid = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_a !== 8'h3C) begin n_fail++; $display("FAIL basic_a got %h exp 3c", bus.out_a); end
    n_tests++; if (bus.out_b !== 8'hA5) begin n_fail++; $display("FAIL basic_b got %h exp a5", bus.out_b); end
    n_tests++; if (bus.out_op !== 4'h5 || bus.out_rd !== 2'd3 || bus.out_imm !== 8'h42)
      begin n_fail++; $display("FAIL basic_pass got op=%h rd=%0d imm=%h exp op=5 rd=3 imm=42", bus.out_op, bus.out_rd, bus.out_imm); end
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_same_edge_fwd();
    issue(4'h6, 2'd1, 2'd2, 2'd0, 8'h01);
    writeback(2'd1, 8'h11);
    step();
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    #2;
    n_tests++; if (bus.out_a !== 8'h11) begin n_fail++; $display("FAIL same_edge_a got %h exp 11", bus.out_a); end
    n_tests++; if (bus.out_b !== 8'hA5) begin n_fail++; $display("FAIL same_edge_b got %h exp a5", bus.out_b); end
    step();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    issue(4'h7, 2'd1, 2'd2, 2'd1, 8'h70);
    step();
    issue(4'h9, 2'd0, 2'd2, 2'd2, 8'h90);
    #2;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall1_in_ready got %b exp 0", bus.in_ready); end
    n_tests++; if (bus.out_b !== 8'hA5) begin n_fail++; $display("FAIL stall1_b got %h exp a5", bus.out_b); end
    step();
    writeback(2'd2, 8'h77);
    #2;
    n_tests++; if (bus.out_b !== 8'h77) begin n_fail++; $display("FAIL stall2_b got %h exp 77", bus.out_b); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall2_in_ready got %b exp 0", bus.in_ready); end
    step();
    bus.wb_en = 1'b0;
    #2;
    n_tests++; if (bus.out_b !== 8'h77) begin n_fail++; $display("FAIL stall3_b got %h exp 77", bus.out_b); end
    n_tests++; if (bus.out_a !== 8'h11) begin n_fail++; $display("FAIL stall3_a got %h exp 11", bus.out_a); end
    n_tests++; if (bus.out_op !== 4'h7 || bus.in_ready !== 1'b0)
      begin n_fail++; $display("FAIL stall3_hold got op=%h in_ready=%b exp op=7 in_ready=0", bus.out_op, bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op !== 4'h9 || bus.out_b !== 8'h77)
      begin n_fail++; $display("FAIL stall_release got v=%b op=%h b=%h exp v=1 op=9 b=77", bus.out_valid, bus.out_op, bus.out_b); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops  [4];
    logic [7:0] imms [4];
    ops[0] = 4'h1; ops[1] = 4'h2; ops[2] = 4'h3; ops[3] = 4'h4;
    imms[0] = 8'hA0; imms[1] = 8'hB1; imms[2] = 8'hC2; imms[3] = 8'hD3;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) issue(ops[i], 2'd1, 2'd2, 2'(i), imms[i]);
      else bus.in_valid = 1'b0;
      #2;
      if (i > 0) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_op !== ops[i-1] || bus.out_imm !== imms[i-1] || bus.out_rd !== 2'(i-1)) begin
          n_fail++;
          $display("FAIL b2b_%0d got v=%b op=%h rd=%0d imm=%h exp v=1 op=%h rd=%0d imm=%h",
                   i, bus.out_valid, bus.out_op, bus.out_rd, bus.out_imm, ops[i-1], i-1, imms[i-1]);
        end
      end
      step();
    end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reset_in_stall();
    bus.out_ready = 1'b0;
    issue(4'hC, 2'd1, 2'd2, 2'd1, 8'h5C);
    step();
    bus.in_valid = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre got %b exp 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rst_stall_async got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    issue(4'hD, 2'd1, 2'd2, 2'd2, 8'h6D);
    step();
    bus.in_valid = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op !== 4'hD || bus.out_a !== 8'h11 || bus.out_b !== 8'h77)
      begin n_fail++; $display("FAIL rst_reissue got v=%b op=%h a=%h b=%h exp v=1 op=d a=11 b=77",
                               bus.out_valid, bus.out_op, bus.out_a, bus.out_b); end
    step();
  endtask

  task automatic test_ra_eq_rb();
    issue(4'hE, 2'd3, 2'd3, 2'd3, 8'hEE);
    writeback(2'd3, 8'h5A);
    step();
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    #2;
    n_tests++; if (bus.out_a !== 8'h5A) begin n_fail++; $display("FAIL same_reg_a got %h exp 5a", bus.out_a); end
    n_tests++; if (bus.out_b !== 8'h5A) begin n_fail++; $display("FAIL same_reg_b got %h exp 5a", bus.out_b); end
    step();
  endtask

  initial begin
    test_reset();
    test_preload_and_basic();
    test_same_edge_fwd();
    test_stall();
    test_back_to_back();
    test_reset_in_stall();
    test_ra_eq_rb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-operand fetch stage of the 8-bit core, sitting between the instruction decoder and the ALU. It accepts decoded instructions over a valid/ready handshake and drives the read ports of `reg_file`. Because `reg_file` reads are registered with one cycle of latency, this stage absorbs that latency and forwards write-back data. It then presents an instruction with resolved operands to the execute stage and routes write-back into `reg_file`.

## Interface
- `WORD`, 8, data width; must match `reg_file`.
- `ADDR_SIZE`, 2, register address width; must match `reg_file`.
- `OP_W`, 4, opcode field width; passed through untouched.

- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoder holds a valid instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_op`  in  OP_W  opcode.
- `in_ra`, `in_rb`, `in_rd`  in  ADDR_SIZE each  source A, source B and destination register.
- `in_imm`  in  WORD  immediate.
- `rf_rd_addr1`, `rf_rd_addr2`  out  ADDR_SIZE  to `reg_file` read ports.
- `rf_rd_data1`, `rf_rd_data2`  in  WORD  from `reg_file`, valid one cycle after address.
- `rf_wr_addr`, `rf_wr_data`, `rf_wr_en`  out  ADDR_SIZE/WORD/1  to `reg_file` write port.
- `wb_en`, `wb_addr`, `wb_data`  in  1/ADDR_SIZE/WORD  write-back from the execute stage.
- `out_valid`  out  1  resolved instruction available.
- `out_ready`  in  1  execute consumes this cycle.
- `out_op`, `out_rd`, `out_imm`  out  OP_W/ADDR_SIZE/WORD  registered passthrough.
- `out_a`, `out_b`  out  WORD  resolved operands.

## Operation
- The port is a single-entry pipeline register (stage B) with two flags: `b_valid` and `b_fresh`. `b_fresh` is 1 only in the first cycle after acceptance.
- `in_ready = !b_valid || out_ready` (combinational). Acceptance occurs when `in_valid && in_ready`. `out_valid = b_valid`.
- `rf_rd_addr1/2 = in_ra/in_rb` combinationally, at all times.
- `rf_wr_*` is driven combinationally from `wb_*`. This stage is the only writer of `reg_file`.
- On the acceptance edge, the stage captures op, ra, rb, rd and imm, and sets `b_fresh`.
  - The stage also captures a same-edge forward per operand: `fwdA = wb_en && wb_addr==in_ra`, together with `wb_data`.
  - This is required because `reg_file` returns the pre-write value when read and write hit the same edge.
- Operand A source, in priority order (operand B is identical, using rb and `rf_rd_data2`):
  1. `wb_en && wb_addr==b_ra` in the current cycle: `out_a = wb_data`, combinationally.
  2. `b_fresh && fwdA`: the captured forward data.
  3. `b_fresh`: `rf_rd_data1`.
  4. Otherwise: the held operand register.
- At every edge while `b_valid`, the held operand register loads the current `out_a`. This keeps the operand correct through stalls and later write-backs.
- Consumption occurs when `out_valid && out_ready`. A simultaneous accept refills stage B, giving a throughput of 1 per cycle.
- Consumption with no accept clears `b_valid`.
- A stall (`out_valid && !out_ready`) holds all `out_*` except `out_a/out_b`, which may change only through write-back forwarding.
- `ra == rb` is legal; both operands resolve identically.

## Timing
- Reset (async, `rst_n` low) sets:
  - `b_valid=0`, `b_fresh=0`, so `out_valid=0` and `in_ready=1`.
  - All held registers and `out_op/out_rd/out_imm` to 0.
  - `out_a/out_b` to 0 unless a write-back is forwarding.
- Reset asserted mid-stall discards the held instruction. There is no replay.
- Latency: accept at edge N, `out_valid` high in cycle N+1 (one cycle).
- Write-back visible to the consumer:
  - The same cycle, for an instruction already in B.
  - The next cycle, for a write on the acceptance edge.
  - Through `reg_file`, for any earlier write.
- No combinational path from `out_ready` to `out_valid`. `in_ready` depends combinationally on `out_ready` (accepted).

## Structure
- The shared package `cpu_pkg` holds `word_t` (`logic [WORD-1:0]`), `reg_addr_t`, `opcode_t`, and the `WORD`/`ADDR_SIZE` defaults shared with `reg_file`.
- One natural sub-module, `operand_fwd`: a per-operand forwarding mux plus holding register, instantiated twice (A and B).

## Test plan
- Preload via write-back r1=0x3C, r2=0xA5. Issue ra=1, rb=2 → one cycle later `out_valid=1`, `out_a=0x3C`, `out_b=0xA5`.
- With r1=0x3C, assert `wb_en`, `wb_addr=1`, `wb_data=0x11` on the acceptance edge of ra=1 → `out_a=0x11`, not 0x3C.
- Hold `out_ready=0` for 3 cycles with rb=2 in B. Write back r2=0x77 in stall cycle 2 → `out_b=0x77` that same cycle and after; `in_ready=0` throughout the stall.
- Four back-to-back instructions with `out_ready=1` → four consecutive `out_valid` cycles with correct op/rd/imm order and no bubbles.
- Drop `rst_n` during a stall with `out_valid=1` → `out_valid=0` and `in_ready=1` immediately, before the next edge. After release, a new issue works normally.
- Issue ra=rb=3 while r3 is written with 0x5A on the acceptance edge → `out_a=out_b=0x5A`.
